// File: rtl/gpr_wb_ctrl.sv
// ---------------------------------------------------------------------------
// gpr_wb_ctrl
// Write-back controller for the 8x8-bit general-purpose register file.
// Three sources share the register file's single write port: ALU results
// (never stalled), buffered load data (small FIFO) and 16-bit CR results
// (one-entry holding register, written to R1:R0). One winner per cycle is
// loaded into an issue register, whose contents drive the write port for
// exactly one cycle.
//
// Optional feature macro: GPR_WB_STARVE_EN
//   defined   - a waiting CR write gains priority over the load FIFO after
//               STARVE_LIMIT cycles of waiting
//   undefined - strictly fixed priority ALU > load > CR
//
// Parameters:
//   STARVE_LIMIT  cycles a held CR may wait before beating loads (1..15)
//   FIFO_DEPTH    load write-back entries buffered (2..4)
//
// Ports:
//   clk                      clock, rising edge
//   rst                      asynchronous reset, active low
//   alu_valid/alu_rd/alu_data ALU write-back request (always accepted)
//   ld_valid/ld_rd/ld_data   load write-back request, ld_ready = FIFO not full
//   cr_valid/cr_in           CR write request, cr_ready = holding reg empty
//   gpr_write[7:0]           per-register write strobes
//   rd_r0_mux                selects cr_data for R1:R0
//   rd_data[7:0]             8-bit write data
//   cr_data[15:0]            16-bit write data for R1:R0
//   reg_busy[7:0]            registers with a write buffered or issuing
//   idle                     nothing buffered and nothing issuing
// ---------------------------------------------------------------------------
module gpr_wb_ctrl #(
  parameter int STARVE_LIMIT = 4,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [2:0]  alu_rd,
  input  logic [7:0]  alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [2:0]  ld_rd,
  input  logic [7:0]  ld_data,
  input  logic        cr_valid,
  output logic        cr_ready,
  input  logic [15:0] cr_in,
  output logic [7:0]  gpr_write,
  output logic        rd_r0_mux,
  output logic [7:0]  rd_data,
  output logic [15:0] cr_data,
  output logic [7:0]  reg_busy,
  output logic        idle
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // Elaboration-time range checks on the parameters.
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 4) begin : g_bad_depth
    $error("gpr_wb_ctrl: FIFO_DEPTH must be 2..4");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
    $error("gpr_wb_ctrl: STARVE_LIMIT must be 1..15");
  end

  // Load FIFO: shift register, entry 0 is the head.
  logic [2:0]       fifo_rd_reg   [FIFO_DEPTH];
  logic [2:0]       fifo_rd_next  [FIFO_DEPTH];
  logic [7:0]       fifo_data_reg [FIFO_DEPTH];
  logic [7:0]       fifo_data_next[FIFO_DEPTH];
  logic [CNT_W-1:0] fifo_cnt_reg, fifo_cnt_next;
  logic [CNT_W-1:0] push_idx;
  logic [7:0]       fifo_busy     [FIFO_DEPTH];

  logic        cr_held_reg, cr_held_next;
  logic [15:0] cr_hold_reg, cr_hold_next;

  logic [7:0]  iss_write_reg, iss_write_next;
  logic        iss_mux_reg, iss_mux_next;
  logic [7:0]  iss_data_reg, iss_data_next;
  logic [15:0] iss_cr_reg, iss_cr_next;

  logic fifo_empty, fifo_full, ld_push, cr_push;
  logic sel_alu, sel_ld, sel_cr, starve_hit;
  logic [7:0] busy_acc;

  assign fifo_empty = (fifo_cnt_reg == '0);
  assign fifo_full  = (fifo_cnt_reg == DEPTH_C);
  assign ld_ready   = !fifo_full;
  assign cr_ready   = !cr_held_reg;
  // Full FIFO refuses a push even when the head pops in the same cycle.
  assign ld_push    = ld_valid && !fifo_full;
  assign cr_push    = cr_valid && !cr_held_reg;

  // Issue arbitration on registered state plus alu_valid.
  assign sel_alu = alu_valid;
  assign sel_cr  = !alu_valid && cr_held_reg && (fifo_empty || starve_hit);
  assign sel_ld  = !alu_valid && !fifo_empty && !sel_cr;

`ifdef GPR_WB_STARVE_EN
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt_reg, starve_cnt_next;

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!cr_held_reg || sel_cr) begin
      starve_cnt_next = '0;
    end else if (starve_cnt_reg != STARVE_MAX) begin
      starve_cnt_next = starve_cnt_reg + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  assign starve_hit = (starve_cnt_reg == STARVE_MAX);
`else
  assign starve_hit = 1'b0;
`endif

  // FIFO next state: pop shifts toward the head, push lands behind the
  // last entry that remains after the pop.
  always_comb begin
    push_idx = sel_ld ? (fifo_cnt_reg - CNT_W'(1)) : fifo_cnt_reg;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      fifo_rd_next[i]   = fifo_rd_reg[i];
      fifo_data_next[i] = fifo_data_reg[i];
    end
    if (sel_ld) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        fifo_rd_next[i]   = fifo_rd_reg[i+1];
        fifo_data_next[i] = fifo_data_reg[i+1];
      end
      fifo_rd_next[FIFO_DEPTH-1]   = '0;
      fifo_data_next[FIFO_DEPTH-1] = '0;
    end
    if (ld_push) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (CNT_W'(i) == push_idx) begin
          fifo_rd_next[i]   = ld_rd;
          fifo_data_next[i] = ld_data;
        end
      end
    end
    case ({ld_push, sel_ld})
      2'b10:   fifo_cnt_next = fifo_cnt_reg + CNT_W'(1);
      2'b01:   fifo_cnt_next = fifo_cnt_reg - CNT_W'(1);
      default: fifo_cnt_next = fifo_cnt_reg;
    endcase
  end

  // CR holding register and issue register next state.
  always_comb begin
    cr_held_next   = cr_held_reg;
    cr_hold_next   = cr_hold_reg;
    iss_write_next = '0;
    iss_mux_next   = 1'b0;
    iss_data_next  = '0;
    iss_cr_next    = '0;
    if (cr_push) begin
      cr_held_next = 1'b1;
      cr_hold_next = cr_in;
    end else if (sel_cr) begin
      cr_held_next = 1'b0;
      cr_hold_next = '0;
    end
    if (sel_alu) begin
      iss_write_next = 8'd1 << alu_rd;
      iss_data_next  = alu_data;
    end else if (sel_ld) begin
      iss_write_next = 8'd1 << fifo_rd_reg[0];
      iss_data_next  = fifo_data_reg[0];
    end else if (sel_cr) begin
      iss_write_next = 8'b0000_0011;
      iss_mux_next   = 1'b1;
      iss_cr_next    = cr_hold_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_rd_reg[i]   <= '0;
        fifo_data_reg[i] <= '0;
      end
      fifo_cnt_reg  <= '0;
      cr_held_reg   <= 1'b0;
      cr_hold_reg   <= '0;
      iss_write_reg <= '0;
      iss_mux_reg   <= 1'b0;
      iss_data_reg  <= '0;
      iss_cr_reg    <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_rd_reg[i]   <= fifo_rd_next[i];
        fifo_data_reg[i] <= fifo_data_next[i];
      end
      fifo_cnt_reg  <= fifo_cnt_next;
      cr_held_reg   <= cr_held_next;
      cr_hold_reg   <= cr_hold_next;
      iss_write_reg <= iss_write_next;
      iss_mux_reg   <= iss_mux_next;
      iss_data_reg  <= iss_data_next;
      iss_cr_reg    <= iss_cr_next;
    end
  end

  // One-hot destination of each occupied FIFO slot.
  genvar gi;
  for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_busy
    assign fifo_busy[gi] = (CNT_W'(gi) < fifo_cnt_reg) ? (8'd1 << fifo_rd_reg[gi]) : 8'd0;
  end

  always_comb begin
    busy_acc = iss_write_reg | (cr_held_reg ? 8'b0000_0011 : 8'd0);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      busy_acc = busy_acc | fifo_busy[i];
    end
  end

  assign gpr_write = iss_write_reg;
  assign rd_r0_mux = iss_mux_reg;
  assign rd_data   = iss_data_reg;
  assign cr_data   = iss_cr_reg;
  assign reg_busy  = busy_acc;
  assign idle      = fifo_empty && !cr_held_reg && (iss_write_reg == 8'd0);

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gpr_wb_ctrl
// Directed bench for gpr_wb_ctrl: a cycle-by-cycle vector table covering
// ALU issue, FIFO fill / ALU priority / full-refusal, CR write and
// simultaneous push/pop, followed by hand-written starvation and mid-stream
// reset sequences.
// ---------------------------------------------------------------------------
module tb_gpr_wb_ctrl;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [2:0]  alu_rd;
  logic [7:0]  alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [2:0]  ld_rd;
  logic [7:0]  ld_data;
  logic        cr_valid;
  logic        cr_ready;
  logic [15:0] cr_in;
  logic [7:0]  gpr_write;
  logic        rd_r0_mux;
  logic [7:0]  rd_data;
  logic [15:0] cr_data;
  logic [7:0]  reg_busy;
  logic        idle;

  int tests;
  int failed;

  gpr_wb_ctrl #(.STARVE_LIMIT(4), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .cr_valid(cr_valid), .cr_ready(cr_ready), .cr_in(cr_in),
    .gpr_write(gpr_write), .rd_r0_mux(rd_r0_mux), .rd_data(rd_data),
    .cr_data(cr_data), .reg_busy(reg_busy), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        alu_v;
    logic [2:0]  alu_r;
    logic [7:0]  alu_d;
    logic        ld_v;
    logic [2:0]  ld_r;
    logic [7:0]  ld_d;
    logic        cr_v;
    logic [15:0] cr_d;
    logic [7:0]  e_wr;
    logic        e_mux;
    logic [7:0]  e_data;
    logic [15:0] e_cr;
    logic [7:0]  e_busy;
    logic        e_ldr;
    logic        e_crr;
    logic        e_idle;
  } vec_t;

  localparam int NVEC = 15;
  vec_t tbl [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] wr, input logic mux,
                         input logic [7:0] data, input logic [15:0] cr,
                         input logic [7:0] busy, input logic ldr, input logic crr,
                         input logic idl);
    chk({tag, " gpr_write"}, 32'(gpr_write), 32'(wr));
    chk({tag, " rd_r0_mux"}, 32'(rd_r0_mux), 32'(mux));
    chk({tag, " rd_data"},   32'(rd_data),   32'(data));
    chk({tag, " cr_data"},   32'(cr_data),   32'(cr));
    chk({tag, " reg_busy"},  32'(reg_busy),  32'(busy));
    chk({tag, " ld_ready"},  32'(ld_ready),  32'(ldr));
    chk({tag, " cr_ready"},  32'(cr_ready),  32'(crr));
    chk({tag, " idle"},      32'(idle),      32'(idl));
  endtask

  task automatic clear_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
    cr_valid  = 1'b0; cr_in  = '0;
  endtask

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [10:0] exp_q[$];
    logic [10:0] e;
    logic [7:0]  oh;
    int          loads_before_cr;
    bit          cr_seen;
    int          exp_loads;

    tests  = 0;
    failed = 0;

    //        alu_v r  data   ld_v r  data   cr_v cr       wr    mux data   cr        busy  ldr crr idle
    tbl[0]  = '{1, 3'd5, 8'hA7, 0, 3'd0, 8'h00, 0, 16'h0000, 8'h20, 0, 8'hA7, 16'h0000, 8'h20, 1, 1, 0};
    tbl[1]  = '{0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 16'h0000, 8'h00, 0, 8'h00, 16'h0000, 8'h00, 1, 1, 1};
    tbl[2]  = '{1, 3'd4, 8'h44, 1, 3'd2, 8'h11, 0, 16'h0000, 8'h10, 0, 8'h44, 16'h0000, 8'h14, 1, 1, 0};
    tbl[3]  = '{1, 3'd4, 8'h45, 1, 3'd3, 8'h22, 0, 16'h0000, 8'h10, 0, 8'h45, 16'h0000, 8'h1C, 0, 1, 0};
    tbl[4]  = '{1, 3'd4, 8'h46, 1, 3'd6, 8'h66, 0, 16'h0000, 8'h10, 0, 8'h46, 16'h0000, 8'h1C, 0, 1, 0};
    tbl[5]  = '{0, 3'd0, 8'h00, 1, 3'd6, 8'h66, 0, 16'h0000, 8'h04, 0, 8'h11, 16'h0000, 8'h0C, 1, 1, 0};
    tbl[6]  = '{0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 16'h0000, 8'h08, 0, 8'h22, 16'h0000, 8'h08, 1, 1, 0};
    tbl[7]  = '{0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 16'h0000, 8'h00, 0, 8'h00, 16'h0000, 8'h00, 1, 1, 1};
    tbl[8]  = '{0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1, 16'hBEEF, 8'h00, 0, 8'h00, 16'h0000, 8'h03, 1, 0, 0};
    tbl[9]  = '{0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 16'h0000, 8'h03, 1, 8'h00, 16'hBEEF, 8'h03, 1, 1, 0};
    tbl[10] = '{0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 16'h0000, 8'h00, 0, 8'h00, 16'h0000, 8'h00, 1, 1, 1};
    tbl[11] = '{0, 3'd0, 8'h00, 1, 3'd1, 8'hAA, 0, 16'h0000, 8'h00, 0, 8'h00, 16'h0000, 8'h02, 1, 1, 0};
    tbl[12] = '{0, 3'd0, 8'h00, 1, 3'd7, 8'hBB, 0, 16'h0000, 8'h02, 0, 8'hAA, 16'h0000, 8'h82, 1, 1, 0};
    tbl[13] = '{0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 16'h0000, 8'h80, 0, 8'hBB, 16'h0000, 8'h80, 1, 1, 0};
    tbl[14] = '{0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 16'h0000, 8'h00, 0, 8'h00, 16'h0000, 8'h00, 1, 1, 1};

    // Power-on reset.
    clear_inputs();
    rst = 1'b0;
    #3;
    chk_all("por", 8'h00, 0, 8'h00, 16'h0000, 8'h00, 1, 1, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Vector table: inputs applied for one cycle, outputs checked 1 after the edge.
    for (int v = 0; v < NVEC; v++) begin
      alu_valid = tbl[v].alu_v; alu_rd = tbl[v].alu_r; alu_data = tbl[v].alu_d;
      ld_valid  = tbl[v].ld_v;  ld_rd  = tbl[v].ld_r;  ld_data  = tbl[v].ld_d;
      cr_valid  = tbl[v].cr_v;  cr_in  = tbl[v].cr_d;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", v), tbl[v].e_wr, tbl[v].e_mux, tbl[v].e_data, tbl[v].e_cr,
              tbl[v].e_busy, tbl[v].e_ldr, tbl[v].e_crr, tbl[v].e_idle);
      $display("[TB] vec%0d applied: gpr_write=%02h rd_data=%02h busy=%02h", v, gpr_write, rd_data, reg_busy);
    end
    clear_inputs();

    // Starvation: CR held while a load is offered every cycle.
`ifdef GPR_WB_STARVE_EN
    exp_loads = 4;
`else
    exp_loads = 10;
`endif
    loads_before_cr = 0;
    cr_seen = 1'b0;
    cr_valid = 1'b1;
    cr_in = 16'h1234;
    for (int s = 0; s < 40; s++) begin
      if (s < 10 && ld_ready) begin
        ld_valid = 1'b1;
        ld_rd    = 3'(2 + (s % 6));
        ld_data  = 8'(8'h50 + s);
        exp_q.push_back({ld_rd, ld_data});
      end else begin
        ld_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      cr_valid = 1'b0;
      if (gpr_write == 8'h03 && rd_r0_mux) begin
        cr_seen = 1'b1;
        chk("starve cr_data", 32'(cr_data), 32'h1234);
        $display("[TB] starve cycle %0d: CR strobe after %0d load strobes", s, loads_before_cr);
      end else if (gpr_write != 8'h00) begin
        if (exp_q.size() == 0) begin
          chk("starve unexpected strobe", 32'(gpr_write), 32'h0);
        end else begin
          e  = exp_q.pop_front();
          oh = 8'd1 << e[10:8];
          chk("starve load order", {16'h0, rd_data, gpr_write}, {16'h0, e[7:0], oh});
          if (!cr_seen) loads_before_cr++;
          $display("[TB] starve cycle %0d: load strobe %02h data %02h", s, gpr_write, rd_data);
        end
      end
      if (s >= 10 && cr_seen && exp_q.size() == 0 && idle) break;
    end
    clear_inputs();
    chk("starve cr issued", 32'(cr_seen), 32'd1);
    chk("starve loads before cr", 32'(loads_before_cr), 32'(exp_loads));
    chk("starve all loads drained", 32'(exp_q.size()), 32'd0);
    chk("starve final idle", 32'(idle), 32'd1);

    // Mid-stream reset with two loads and one CR buffered.
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 3'd4; alu_data = 8'h01;
    ld_valid = 1'b1; ld_rd = 3'd2; ld_data = 8'h05;
    cr_valid = 1'b1; cr_in = 16'hC0DE;
    @(posedge clk);
    #1;
    cr_valid = 1'b0;
    ld_rd = 3'd3; ld_data = 8'h06;
    @(posedge clk);
    #1;
    chk("rst pre busy", 32'(reg_busy), 32'h1F);
    chk("rst pre ld_ready", 32'(ld_ready), 32'd0);
    clear_inputs();
    #1;
    rst = 1'b0;
    #1;
    chk_all("rst async", 8'h00, 0, 8'h00, 16'h0000, 8'h00, 1, 1, 1);
    $display("[TB] mid-stream reset asserted");
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk_all($sformatf("post-rst%0d", c), 8'h00, 0, 8'h00, 16'h0000, 8'h00, 1, 1, 1);
      $display("[TB] post-reset cycle %0d: gpr_write=%02h idle=%0d", c, gpr_write, idle);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
